// File: rtl/tick_scheduler.sv
// tick_scheduler: shared timebase for the PicoBlaze cores.
// A prescaler divides clk into a base tick. Four channels divide the base
// tick again and produce a one-cycle tick pulse, a square-wave toggle and a
// sticky status flag. Registers sit on the PicoBlaze port bus, and a
// maskable level interrupt is raised from the status flags.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   port_id      PicoBlaze port address
//   write_strobe single-cycle write qualifier
//   out_port     write data
//   in_port      registered read data (1-cycle latency)
//   tick         per-channel one-cycle pulse
//   toggle       per-channel square wave, flips on each tick
//   irq          level interrupt, |(STATUS & MASK), registered
//   irq_ack      reserved, not used by the logic
//
// Register map (offset from BASE_ADDR):
//   +0 CTRL    [3:0] channel enable
//   +1..+4     PERIOD0..PERIOD3
//   +5 STATUS  [3:0] sticky flags, write 1 to clear
//   +6 MASK    [3:0] irq mask
module tick_scheduler #(
  parameter int unsigned PRESCALE  = 200000,
  parameter logic [7:0]  BASE_ADDR = 8'h40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic [3:0] tick,
  output logic [3:0] toggle,
  output logic       irq,
  input  logic       irq_ack
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_PERIOD0 = 3'd1,
    REG_PERIOD1 = 3'd2,
    REG_PERIOD2 = 3'd3,
    REG_PERIOD3 = 3'd4,
    REG_STATUS  = 3'd5,
    REG_MASK    = 3'd6
  } reg_e;

  logic [PW-1:0] pre;
  logic          base_tick;

  logic [3:0] ctrl;
  logic [3:0] status;
  logic [3:0] mask;
  logic [7:0] period [4];
  logic [7:0] cnt    [4];

  logic [7:0] off;
  logic       hit;
  logic       wr_ctrl;
  logic       wr_status;
  logic       wr_mask;
  logic [3:0] wr_period;
  logic [3:0] clr;
  logic [3:0] load;
  logic [3:0] run;
  logic [3:0] fire;
  logic [7:0] rd_data;

  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;

  assign base_tick = (pre == PW'(PRESCALE - 1));

  // Address decode: offset relative to BASE_ADDR, valid for 0..6.
  always_comb begin
    off       = port_id - BASE_ADDR;
    hit       = (off < 8'd7);
    wr_ctrl   = write_strobe && hit && (off[2:0] == REG_CTRL);
    wr_status = write_strobe && hit && (off[2:0] == REG_STATUS);
    wr_mask   = write_strobe && hit && (off[2:0] == REG_MASK);
    wr_period = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      wr_period[i] = write_strobe && hit && (off[2:0] == 3'(i + 1));
    end
    clr = wr_status ? out_port[3:0] : '0;
  end

  // Channel control. load: enable rising edge by a CTRL write (beats base
  // tick). run: enabled now and not being disabled by this very write, so a
  // disable coinciding with a would-be tick suppresses it.
  always_comb begin
    load = '0;
    run  = '0;
    fire = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      load[i] = wr_ctrl && out_port[i] && !ctrl[i];
      run[i]  = ctrl[i] && !(wr_ctrl && !out_port[i]);
      fire[i] = run[i] && base_tick && (cnt[i] == 8'd0);
    end
  end

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (off[2:0])
        REG_CTRL:    rd_data = {4'b0, ctrl};
        REG_PERIOD0: rd_data = period[0];
        REG_PERIOD1: rd_data = period[1];
        REG_PERIOD2: rd_data = period[2];
        REG_PERIOD3: rd_data = period[3];
        REG_STATUS:  rd_data = {4'b0, status};
        REG_MASK:    rd_data = {4'b0, mask};
        default:     rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre     <= '0;
      ctrl    <= '0;
      status  <= '0;
      mask    <= '0;
      tick    <= '0;
      toggle  <= '0;
      irq     <= 1'b0;
      in_port <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      pre <= base_tick ? '0 : pre + 1'b1;

      if (wr_ctrl) ctrl <= out_port[3:0];
      if (wr_mask) mask <= out_port[3:0];

      // Reload uses the PERIOD value held before any same-cycle write.
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_period[i]) period[i] <= out_port;
        if (load[i]) begin
          cnt[i] <= period[i];
        end else if (run[i] && base_tick) begin
          if (cnt[i] == 8'd0) cnt[i] <= period[i];
          else                cnt[i] <= cnt[i] - 8'd1;
        end
      end

      tick   <= fire;
      toggle <= toggle ^ fire;
      // A tick's set outranks a same-cycle write-1-clear of that bit.
      status <= (status & ~clr) | fire;
      irq    <= |(status & mask);
      in_port <= rd_data;
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with PRESCALE=4, BASE_ADDR=8'h40.
// Expected values are pushed to a queue and popped at each comparison.
module tb_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic [3:0] tick;
  logic [3:0] toggle;
  logic       irq;
  logic       irq_ack;

  int total = 0;
  int bad   = 0;
  int exp_q [$];

  // Independent prescaler phase model: value is the count seen by the next edge.
  int ph = 0;
  int n  = 0;

  tick_scheduler #(.PRESCALE(4), .BASE_ADDR(8'h40)) dut (
    .clk(clk), .rst(rst), .port_id(port_id), .write_strobe(write_strobe),
    .out_port(out_port), .in_port(in_port), .tick(tick), .toggle(toggle),
    .irq(irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    n <= n + 1;
    if (rst) ph <= 0;
    else     ph <= (ph == 3) ? 0 : ph + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, output int e, output int p);
    p = ph;
    port_id = a;
    out_port = d;
    write_strobe = 1'b1;
    step();
    e = n;
    write_strobe = 1'b0;
    port_id = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    port_id = a;
    step();
    v = in_port;
    port_id = 8'h00;
  endtask

  task automatic wait_tick(input int ch, input int budget, output int e);
    e = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (tick[ch]) begin
        e = n;
        break;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs);
    int ex;
    total++;
    if (exp_q.size() == 0) ex = -999;
    else ex = exp_q.pop_front();
    assert (obs === ex) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, ex);
    end
  endtask

  // Edges from an edge whose prescaler phase is p to the next base-tick edge.
  function automatic int k1(input int p);
    return (p == 3) ? 4 : (3 - p);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e, p, t, t2, t3, cnt_t;
    logic [7:0] v;
    rst = 1'b1;
    port_id = 8'h00;
    write_strobe = 1'b0;
    out_port = 8'h00;
    irq_ack = 1'b0;
    step();
    step();
    exp_q.push_back(0); chk("rst_tick", int'(tick));
    exp_q.push_back(0); chk("rst_toggle", int'(toggle));
    exp_q.push_back(0); chk("rst_irq", int'(irq));
    rst = 1'b0;
    for (int a = 8'h40; a <= 8'h47; a++) begin
      rd(8'(a), v);
      exp_q.push_back(0); chk($sformatf("rst_rd_%0h", a), int'(v));
    end

    // Channel 0, PERIOD=2: every 12 clk.
    wr(8'h41, 8'd2, e, p);
    wr(8'h40, 8'h01, e, p);
    exp_q.push_back(e + k1(p) + 8);
    wait_tick(0, 40, t);
    chk("ch0_first", t);
    exp_q.push_back(1); chk("ch0_tog1", int'(toggle[0]));
    step();
    exp_q.push_back(0); chk("ch0_width", int'(tick[0]));
    exp_q.push_back(t + 12);
    wait_tick(0, 40, t2);
    chk("ch0_period", t2);
    exp_q.push_back(0); chk("ch0_tog2", int'(toggle[0]));
    wr(8'h40, 8'h00, e, p);

    // Channels 1 and 3 with PERIOD 0 and 1.
    wr(8'h42, 8'd0, e, p);
    wr(8'h44, 8'd1, e, p);
    wr(8'h45, 8'h0F, e, p);
    wr(8'h40, 8'h0A, e, p);
    exp_q.push_back(e + k1(p) + 4);
    wait_tick(3, 40, t);
    chk("ch3_first", t);
    rd(8'h45, v);
    exp_q.push_back(8'h0A); chk("status_1010", int'(v));
    wait_tick(1, 20, t);
    wait_tick(1, 20, t2);
    exp_q.push_back(4); chk("ch1_spacing", t2 - t);
    wait_tick(3, 20, t);
    wait_tick(3, 20, t2);
    exp_q.push_back(8); chk("ch3_spacing", t2 - t);

    // Interrupt behaviour on channel 1.
    wr(8'h46, 8'h02, e, p);
    for (int i = 0; i < 8 && ph != 0; i++) step();
    wr(8'h45, 8'h02, e, p);
    exp_q.push_back(1); chk("irq_hold", int'(irq));
    step();
    exp_q.push_back(0); chk("irq_fall", int'(irq));
    wait_tick(1, 8, t);
    exp_q.push_back(0); chk("irq_before_rise", int'(irq));
    step();
    exp_q.push_back(1); chk("irq_rise", int'(irq));
    for (int i = 0; i < 8 && ph != 3; i++) step();
    wr(8'h45, 8'h02, e, p);
    rd(8'h45, v);
    exp_q.push_back(1); chk("clr_vs_tick", int'(v[1]));

    // Channel 2: PERIOD change mid-count, then disable on a tick edge.
    wr(8'h40, 8'h00, e, p);
    wr(8'h43, 8'd5, e, p);
    wr(8'h40, 8'h04, e, p);
    exp_q.push_back(e + k1(p) + 20);
    wait_tick(2, 40, t);
    chk("ch2_first", t);
    repeat (6) step();
    wr(8'h43, 8'd1, e, p);
    exp_q.push_back(t + 24);
    wait_tick(2, 40, t2);
    chk("p2_keep", t2);
    exp_q.push_back(t2 + 8);
    wait_tick(2, 20, t3);
    chk("p2_new", t3);
    wr(8'h45, 8'h0F, e, p);
    for (int i = 0; i < 12 && n < t3 + 7; i++) step();
    wr(8'h40, 8'h00, e, p);
    exp_q.push_back(t3 + 8); chk("dis_edge", e);
    exp_q.push_back(0); chk("dis_no_tick", int'(tick[2]));
    exp_q.push_back(1); chk("dis_tog_hold", int'(toggle[2]));
    cnt_t = 0;
    repeat (16) begin
      step();
      if (tick != 4'b0) cnt_t++;
    end
    exp_q.push_back(0); chk("dis_quiet", cnt_t);
    exp_q.push_back(1); chk("dis_tog_final", int'(toggle[2]));
    rd(8'h45, v);
    exp_q.push_back(0); chk("dis_no_flag", int'(v));

    // Reset mid-run.
    wr(8'h41, 8'd2, e, p);
    wr(8'h42, 8'd0, e, p);
    wr(8'h40, 8'h03, e, p);
    wait_tick(1, 20, t);
    step();
    exp_q.push_back(1); chk("pre_rst_irq", int'(irq));
    rst = 1'b1;
    port_id = 8'h40;
    step();
    rst = 1'b0;
    exp_q.push_back(0); chk("mid_rst_tick", int'(tick));
    exp_q.push_back(0); chk("mid_rst_toggle", int'(toggle));
    exp_q.push_back(0); chk("mid_rst_irq", int'(irq));
    exp_q.push_back(0); chk("mid_rst_in_port", int'(in_port));
    port_id = 8'h00;
    cnt_t = 0;
    repeat (24) begin
      step();
      if (tick != 4'b0) cnt_t++;
    end
    exp_q.push_back(0); chk("post_rst_quiet", cnt_t);
    rd(8'h40, v);
    exp_q.push_back(0); chk("post_rst_ctrl", int'(v));
    rd(8'h41, v);
    exp_q.push_back(0); chk("post_rst_period0", int'(v));
    rd(8'h46, v);
    exp_q.push_back(0); chk("post_rst_mask", int'(v));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
